seq_shift_reg: RTL and testbench

SEQ_SHIFT_REG -- requirements
Module: seq_shift_reg

---
 rtl/alu_pkg.sv | 26 ++
 rtl/shift_step.sv | 45 ++++
 rtl/seq_shift_reg.sv | 89 ++++++++
 tb/tb_seq_shift_reg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential shifter: operation codes, FSM states and an op classifier.
package alu_pkg;

  typedef enum logic [2:0] {
    OpLoad = 3'd0,
    OpShl  = 3'd1,
    OpShr  = 3'd2,
    OpSar  = 3'd3,
    OpRol  = 3'd4,
    OpRor  = 3'd5,
    OpRsv6 = 3'd6,
    OpRsv7 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // LOAD and the reserved codes complete without any shift cycles.
  function automatic logic op_shifts(op_e op);
    return op inside {OpShl, OpShr, OpSar, OpRol, OpRor};
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step: next q and the bit moved out, for one SHIFT cycle.
module shift_step
  import alu_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] q,
  input  op_e              op,
  input  logic             ser_in,
  output logic [Width-1:0] q_next,
  output logic             carry_next
);

  always_comb begin
    q_next     = q;
    carry_next = 1'b0;
    unique case (op)
      OpShl: begin
        q_next     = {q[Width-2:0], ser_in};
        carry_next = q[Width-1];
      end
      OpShr: begin
        q_next     = {ser_in, q[Width-1:1]};
        carry_next = q[0];
      end
      OpSar: begin
        q_next     = {q[Width-1], q[Width-1:1]};
        carry_next = q[0];
      end
      OpRol: begin
        q_next     = {q[Width-2:0], q[Width-1]};
        carry_next = q[Width-1];
      end
      OpRor: begin
        q_next     = {q[0], q[Width-1:1]};
        carry_next = q[0];
      end
      default: begin
        q_next     = q;
        carry_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_reg.sv
// Sequential multi-cycle shifter: accepts an operand and count, shifts one bit per cycle.
module seq_shift_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d_in,
  input  logic [AMT_W-1:0] amt,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             carry
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] q_q;
  logic             carry_q;
  logic [AMT_W-1:0] count_q;

  logic             accept;
  state_e           accept_state;
  logic [WIDTH-1:0] step_q;
  logic             step_carry;

  // Start is only honoured outside SHIFT; a request while busy is dropped.
  assign accept       = start && (state_q != StShift);
  assign accept_state = ((amt == '0) || !op_shifts(op_e'(op))) ? StDone : StShift;

  shift_step #(
    .Width (WIDTH)
  ) u_shift_step (
    .q          (q_q),
    .op         (op_q),
    .ser_in     (ser_in),
    .q_next     (step_q),
    .carry_next (step_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = accept_state;
      StShift: if (count_q == AMT_W'(1)) state_d = StDone;
      StDone:  state_d = start ? accept_state : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q     <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      op_q    <= OpLoad;
    end else if (accept) begin
      q_q     <= d_in;
      carry_q <= 1'b0;
      count_q <= amt;
      op_q    <= op_e'(op);
    end else if (state_q == StShift) begin
      q_q     <= step_q;
      carry_q <= step_carry;
      count_q <= count_q - AMT_W'(1);
    end
  end

  always_comb begin
    busy  = (state_q == StShift);
    done  = (state_q == StDone);
    q     = q_q;
    carry = carry_q;
  end

endmodule

// File: tb/tb_seq_shift_reg.sv
// Bench for seq_shift_reg: cycle-level reference model compared every cycle plus directed literal checks.
module tb_seq_shift_reg;

  localparam int unsigned W    = 8;
  localparam int unsigned AW   = 4;
  localparam int unsigned MASK = (1 << W) - 1;
  localparam int unsigned MSB  = 1 << (W - 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  d_in;
  logic [AW-1:0] amt;
  logic          ser_in;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;
  logic          carry;

  int n_checks = 0;
  int n_fail   = 0;

  seq_shift_reg #(
    .WIDTH (W),
    .AMT_W (AW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .d_in   (d_in),
    .amt    (amt),
    .ser_in (ser_in),
    .q      (q),
    .busy   (busy),
    .done   (done),
    .carry  (carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 shifting, 2 done; arithmetic on plain integers.
  int unsigned m_q, m_carry, m_rem, m_op;
  int          m_phase;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q = 0; m_carry = 0; m_rem = 0; m_phase = 0; m_op = 0;
      m_valid = 1'b1;
    end else if (start && m_phase != 1) begin
      m_q = d_in; m_carry = 0; m_rem = amt; m_op = op;
      m_phase = (amt == 0 || op == 0 || op > 5) ? 2 : 1;
    end else if (m_phase == 1) begin
      case (m_op)
        1: begin m_carry = (m_q >> (W-1)) & 1; m_q = ((m_q << 1) | ser_in) & MASK; end
        2: begin m_carry = m_q & 1; m_q = (m_q >> 1) | (ser_in ? MSB : 0); end
        3: begin m_carry = m_q & 1; m_q = (m_q >> 1) | (m_q & MSB); end
        4: begin m_carry = (m_q >> (W-1)) & 1; m_q = ((m_q << 1) | m_carry) & MASK; end
        default: begin m_carry = m_q & 1; m_q = (m_q >> 1) | (m_carry ? MSB : 0); end
      endcase
      m_rem--;
      if (m_rem == 0) m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q", q, m_q);
      check("model_carry", carry, m_carry);
      check("model_busy", busy, (m_phase == 1) ? 1 : 0);
      check("model_done", done, (m_phase == 2) ? 1 : 0);
    end
  end

  task automatic issue(input int unsigned o, input int unsigned d, input int unsigned a,
                       input bit s);
    @(negedge clk);
    start = 1'b1; op = 3'(o); d_in = W'(d); amt = AW'(a); ser_in = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles, then checks the literal result.
  task automatic finish_op(input string name, input int unsigned exp_q, input int unsigned exp_c,
                           input int unsigned exp_busy);
    int unsigned nb = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) nb++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_q"}, q, exp_q);
    check({name, "_carry"}, carry, exp_c);
    check({name, "_busy_cycles"}, nb, exp_busy);
  endtask

  task automatic run_op(input string name, input int unsigned o, input int unsigned d,
                        input int unsigned a, input bit s, input int unsigned exp_q,
                        input int unsigned exp_c, input int unsigned exp_busy);
    issue(o, d, a, s);
    finish_op(name, exp_q, exp_c, exp_busy);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; d_in = '0; amt = '0; ser_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_q", q, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_carry", carry, 0);
    rst_n = 1'b1;

    run_op("shl_81_1", 1, 'h81, 1, 1'b0, 'h02, 1, 1);
    run_op("sar_80_3", 3, 'h80, 3, 1'b0, 'hF0, 0, 3);
    run_op("shr_ff_4", 2, 'hFF, 4, 1'b1, 'hFF, 1, 4);
    run_op("ror_01_9", 5, 'h01, 9, 1'b0, 'h80, 1, 9);
    run_op("load_5a", 0, 'h5A, 3, 1'b0, 'h5A, 0, 0);
    run_op("shl_amt0", 1, 'h5A, 0, 1'b1, 'h5A, 0, 0);
    run_op("rsv6", 6, 'h33, 2, 1'b0, 'h33, 0, 0);
    run_op("sar_80_10", 3, 'h80, 10, 1'b0, 'hFF, 1, 10);
    run_op("shl_ff_10", 1, 'hFF, 10, 1'b0, 'h00, 0, 10);
    run_op("rol_c3_2", 4, 'hC3, 2, 1'b0, 'h0F, 1, 2);

    // Start during a shift is dropped; the original op completes.
    issue(1, 'h01, 5, 1'b0);
    start = 1'b1; op = 3'd2; d_in = 8'hAA; amt = 4'd2; ser_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    finish_op("shl_ignored", 'h20, 0, 4);
    // Start held at done: back-to-back accept.
    start = 1'b1; op = 3'd4; d_in = 8'h80; amt = 4'd1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    finish_op("b2b_rol", 'h01, 1, 1);

    // Reset mid-shift aborts without a done pulse.
    issue(4, 'h81, 6, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_q", q, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_done_late", done, 0);
    run_op("after_abort", 1, 'h03, 2, 1'b1, 'h0F, 0, 2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
